fast_mult: RTL and testbench
============================

Name: fast_mult

Overview:
- Unsigned WIDTH x WIDTH integer multiplier for datapath use.
- Fast combinational product path: AND-array partial products, carry-save (Wallace/Dadda) reduction tree, final carry-propagate adder.
- Also provides a one-stage registered copy of the product with a valid flag, so clocked consumers can take a timing-clean result.
- Default configuration is 4x4 -> 8 bits.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16); product width is 2*WIDTH.

Ports:
- clk  input  1  clock; all registers update on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- lhs  input  WIDTH  multiplicand.
- rhs  input  WIDTH  multiplier.
- in_valid  input  1  qualifies lhs/rhs for capture into the registered stage.
- out  output  2*WIDTH  combinational product lhs*rhs.
- out_q  output  2*WIDTH  registered product.
- out_valid  output  1  out_q holds a valid result.

Behaviour:
- out:
  - Purely combinational; out == lhs * rhs at all times, independent of clk, reset and in_valid.
  - Zero cycles of latency; settles within one simulation time step after an input change.
- Width rule: full 2*WIDTH-bit product, never truncated. Maximum (2^WIDTH-1)^2 fits exactly, e.g. 15*15 = 225 = 8'hE1.
- Structure:
  - WIDTH^2 partial-product bits p[i][j] = lhs[j] & rhs[i], weight 2^(i+j).
  - Columns reduced with full/half adders until at most two rows remain.
  - Final ripple or prefix adder produces out.
  - No behavioural "*" operator.
- Registered stage:
  - On rising clk with reset==1 and in_valid==1: out_q <= out (current lhs*rhs), out_valid <= 1.
  - On rising clk with reset==1 and in_valid==0: out_q holds its value, out_valid <= 0.
  - Latency is 1 cycle from sampled in_valid to out_valid.
  - One result per cycle throughput; no backpressure or ready signal.
- Reset:
  - On rising clk with reset==0: out_q <= 0, out_valid <= 0.
  - Reset overrides in_valid.
  - Reset asserted mid-operation discards the captured result.
  - out (combinational) is unaffected by reset.
- Boundary cases:
  - Either operand 0 -> product 0.
  - Operand 1 -> product equals the other operand zero-extended.
  - X/Z on inputs is not required to be handled.

Optional Feature:
- Macro: FAST_MULT_SIGNED_EN.
- Defined:
  - lhs, rhs, out and out_q are two's complement.
  - Product computed with Baugh-Wooley sign correction: invert MSB-row/column partial products, add correction constants.
  - Examples for WIDTH=4: (-1)*(-1) = 8'h01; (-8)*7 = -56 = 8'hC8; (-8)*(-8) = 64 = 8'h40.
- Not defined: operands and product are unsigned as described above.
- Port list, latency and reset behaviour are identical in both builds.

Test Plan:
- lhs=2, rhs=3, no clock edge, check at +1 time unit -> out==8'h06.
- Exhaustive sweep, lhs and rhs each 0..15 -> out == lhs*rhs for all 256 pairs. Spot checks: 15*15 -> 8'hE1; 0*9 -> 8'h00; 1*13 -> 8'h0D.
- reset=0 for 2 cycles, then reset=1, in_valid=1, lhs=5, rhs=7 -> after next edge out_q==8'h23, out_valid==1. Then in_valid=0 for one edge -> out_valid==0, out_q stays 8'h23.
- Back-to-back in_valid=1 with (3,4), (9,9), (15,1) on consecutive cycles -> out_q==8'h0C, then 8'h51, then 8'h0F on successive edges, out_valid held 1.
- reset driven 0 on the edge where in_valid=1, lhs=6, rhs=6 -> out_q==0, out_valid==0, while out==8'h24 combinationally.
- With FAST_MULT_SIGNED_EN defined: lhs=4'hF, rhs=4'hF -> out==8'h01; lhs=4'h8, rhs=4'h7 -> out==8'hC8.

Source files
------------

// File: rtl/fast_mult.sv
// Unsigned WIDTH x WIDTH multiplier: AND-array, carry-save row reduction, ripple CPA, plus one registered stage.
// Define FAST_MULT_SIGNED_EN for a two's-complement build using Baugh-Wooley correction.
module fast_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     lhs,
  input  logic [WIDTH-1:0]     rhs,
  input  logic                 in_valid,
  output logic [2*WIDTH-1:0]   out,
  output logic [2*WIDTH-1:0]   out_q,
  output logic                 out_valid
);

  localparam int PW     = 2 * WIDTH;
  localparam int NR     = WIDTH + 1;
  localparam int IW     = $clog2(NR);
  localparam int PIW    = $clog2(PW);
  localparam int LEVELS = 8;

  logic [PW-1:0] pp_row [NR];
  logic [PW-1:0] sum_a;
  logic [PW-1:0] sum_b;
  logic [PW-1:0] prod;
  logic [PW-1:0] prod_q, prod_d;
  logic          valid_q, valid_d;

  // One row per multiplier bit, already shifted to its weight.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    logic [WIDTH-1:0] bits;
`ifdef FAST_MULT_SIGNED_EN
    localparam logic [WIDTH-1:0] INV_MASK = (i == WIDTH - 1) ?
        {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    assign bits = (lhs & {WIDTH{rhs[i]}}) ^ INV_MASK;
`else
    assign bits = lhs & {WIDTH{rhs[i]}};
`endif
    assign pp_row[i] = {{WIDTH{1'b0}}, bits} << i;
  end

`ifdef FAST_MULT_SIGNED_EN
  assign pp_row[WIDTH] = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
`else
  assign pp_row[WIDTH] = '0;
`endif

  // Rows are compressed three-at-a-time by 3:2 counters each level until two remain;
  // carries past bit PW-1 are dropped since the result is taken modulo 2^PW.
  always_comb begin
    logic [PW-1:0] cur [NR];
    logic [PW-1:0] nxt [NR];
    logic [PW-1:0] a, b, c;
    int unsigned   n, nn;
    cur = pp_row;
    nxt = '{default: '0};
    a   = '0;
    b   = '0;
    c   = '0;
    n   = NR;
    nn  = 0;
    for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
      nxt = '{default: '0};
      nn  = 0;
      for (int unsigned g = 0; g < NR; g += 3) begin
        if (g + 2 < n) begin
          a = cur[IW'(g)];
          b = cur[IW'(g + 1)];
          c = cur[IW'(g + 2)];
          nxt[IW'(nn)]     = a ^ b ^ c;
          nxt[IW'(nn + 1)] = ((a & b) | (a & c) | (b & c)) << 1;
          nn = nn + 2;
        end else if (g < n) begin
          nxt[IW'(nn)] = cur[IW'(g)];
          nn = nn + 1;
          if (g + 1 < n) begin
            nxt[IW'(nn)] = cur[IW'(g + 1)];
            nn = nn + 1;
          end
        end
      end
      cur = nxt;
      n   = nn;
    end
    sum_a = cur[0];
    sum_b = cur[1];
  end

  always_comb begin
    logic carry;
    carry = 1'b0;
    prod  = '0;
    for (int unsigned k = 0; k < PW; k++) begin
      prod[PIW'(k)] = sum_a[PIW'(k)] ^ sum_b[PIW'(k)] ^ carry;
      carry = (sum_a[PIW'(k)] & sum_b[PIW'(k)]) |
              (carry & (sum_a[PIW'(k)] ^ sum_b[PIW'(k)]));
    end
  end

  assign out = prod;

  always_comb begin
    prod_d  = prod_q;
    valid_d = 1'b0;
    if (in_valid) begin
      prod_d  = prod;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign out_q     = prod_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_fast_mult.sv
// Self-checking bench for fast_mult (WIDTH=4); honours FAST_MULT_SIGNED_EN when defined.
module tb_fast_mult;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] lhs = '0;
  logic [W-1:0] rhs = '0;
  logic [2*W-1:0] out;
  logic [2*W-1:0] out_q;
  logic           out_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [2*W-1:0] sb_q [$];
  logic [2*W-1:0] held = '0;

  fast_mult #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .lhs      (lhs),
    .rhs      (rhs),
    .in_valid (in_valid),
    .out      (out),
    .out_q    (out_q),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y;
`ifdef FAST_MULT_SIGNED_EN
    x = $signed(a);
    y = $signed(b);
`else
    x = int'(a);
    y = int'(b);
`endif
    return (2*W)'(x * y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; lhs = 4'd5; rhs = 4'd7;
    tick(); tick();
    total_cnt++;
    if (out_q !== 8'h00) $display("FAIL reset_out_q: got %h expected %h", out_q, 8'h00);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected %b", out_valid, 1'b0);
    else pass_cnt++;
  endtask

  task automatic test_comb_basic();
    lhs = 4'd2; rhs = 4'd3;
    #1;
    total_cnt++;
    if (out !== 8'h06) $display("FAIL comb_2x3: got %h expected %h", out, 8'h06);
    else pass_cnt++;
  endtask

  task automatic test_exhaustive();
    logic [2*W-1:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        lhs = 4'(a); rhs = 4'(b);
        exp = model(4'(a), 4'(b));
        #1;
        total_cnt++;
        if (out !== exp) $display("FAIL sweep %0d*%0d: got %h expected %h", a, b, out, exp);
        else pass_cnt++;
      end
    end
`ifdef FAST_MULT_SIGNED_EN
    lhs = 4'hF; rhs = 4'hF; #1; total_cnt++;
    if (out !== 8'h01) $display("FAIL spot_m1xm1: got %h expected %h", out, 8'h01); else pass_cnt++;
    lhs = 4'h8; rhs = 4'h7; #1; total_cnt++;
    if (out !== 8'hC8) $display("FAIL spot_m8x7: got %h expected %h", out, 8'hC8); else pass_cnt++;
    lhs = 4'h8; rhs = 4'h8; #1; total_cnt++;
    if (out !== 8'h40) $display("FAIL spot_m8xm8: got %h expected %h", out, 8'h40); else pass_cnt++;
    lhs = 4'h1; rhs = 4'hD; #1; total_cnt++;
    if (out !== 8'hFD) $display("FAIL spot_1xm3: got %h expected %h", out, 8'hFD); else pass_cnt++;
`else
    lhs = 4'd15; rhs = 4'd15; #1; total_cnt++;
    if (out !== 8'hE1) $display("FAIL spot_15x15: got %h expected %h", out, 8'hE1); else pass_cnt++;
    lhs = 4'd1; rhs = 4'd13; #1; total_cnt++;
    if (out !== 8'h0D) $display("FAIL spot_1x13: got %h expected %h", out, 8'h0D); else pass_cnt++;
`endif
    lhs = 4'd0; rhs = 4'd9; #1; total_cnt++;
    if (out !== 8'h00) $display("FAIL spot_0x9: got %h expected %h", out, 8'h00); else pass_cnt++;
  endtask

  task automatic test_registered();
    logic [2*W-1:0] exp;
    tick();
    reset = 1'b1; in_valid = 1'b1; lhs = 4'd5; rhs = 4'd7;
    sb_q.push_back(model(lhs, rhs));
    tick();
    exp = sb_q.pop_front();
    total_cnt++;
    if (out_q !== exp || out_q !== 8'h23) $display("FAIL reg_capture: got %h expected %h", out_q, 8'h23);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL reg_valid: got %b expected %b", out_valid, 1'b1);
    else pass_cnt++;
    in_valid = 1'b0; lhs = 4'd9; rhs = 4'd2;
    tick();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reg_idle_valid: got %b expected %b", out_valid, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (out_q !== 8'h23) $display("FAIL reg_hold: got %h expected %h", out_q, 8'h23);
    else pass_cnt++;
    held = 8'h23;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] la [3];
    logic [W-1:0] ra [3];
    logic [2*W-1:0] exp;
    la[0] = 4'd3; ra[0] = 4'd4;
    la[1] = 4'd9; ra[1] = 4'd9;
    la[2] = 4'd15; ra[2] = 4'd1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; lhs = la[k]; rhs = ra[k];
      sb_q.push_back(model(lhs, rhs));
      tick();
      exp = sb_q.pop_front();
      held = exp;
      total_cnt++;
      if (out_q !== exp) $display("FAIL b2b_%0d_out_q: got %h expected %h", k, out_q, exp);
      else pass_cnt++;
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL b2b_%0d_valid: got %b expected %b", k, out_valid, 1'b1);
      else pass_cnt++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random_stream();
    logic           v;
    logic [2*W-1:0] exp;
    for (int k = 0; k < 60; k++) begin
      v = 1'($urandom_range(0, 1));
      in_valid = v; lhs = 4'($urandom); rhs = 4'($urandom);
      if (v) sb_q.push_back(model(lhs, rhs));
      tick();
      if (v) begin
        exp = sb_q.pop_front();
        held = exp;
        total_cnt++;
        if (out_q !== exp || out_valid !== 1'b1)
          $display("FAIL stream_%0d_capture: got %h/%b expected %h/1", k, out_q, out_valid, exp);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (out_q !== held || out_valid !== 1'b0)
          $display("FAIL stream_%0d_hold: got %h/%b expected %h/0", k, out_q, out_valid, held);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_override();
    in_valid = 1'b1; lhs = 4'd5; rhs = 4'd3;
    tick();
    total_cnt++;
    if (out_q !== 8'h0F) $display("FAIL ovr_precapture: got %h expected %h", out_q, 8'h0F);
    else pass_cnt++;
    reset = 1'b0; in_valid = 1'b1; lhs = 4'd6; rhs = 4'd6;
    #1;
    total_cnt++;
    if (out !== 8'h24) $display("FAIL ovr_comb_before: got %h expected %h", out, 8'h24);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_q !== 8'h00 || out_valid !== 1'b0)
      $display("FAIL ovr_discard: got %h/%b expected 00/0", out_q, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out !== 8'h24) $display("FAIL ovr_comb_after: got %h expected %h", out, 8'h24);
    else pass_cnt++;
    reset = 1'b1; in_valid = 1'b0;
    tick();
    total_cnt++;
    if (out_q !== 8'h00 || out_valid !== 1'b0)
      $display("FAIL ovr_release: got %h/%b expected 00/0", out_q, out_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_comb_basic();
    test_exhaustive();
    test_registered();
    test_back_to_back();
    test_random_stream();
    test_reset_override();
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d expected %0d", sb_q.size(), 0);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
